onchip_mem_arbiter: RTL and testbench
=====================================

// Module: onchip_mem_arbiter
// PURPOSE
//   Shares the single-port on-chip frame memory between two requesters on mem_clk:
//   M0 = wps_controller (read/write, config and frame staging), M1 = onchip_mem_usr_logic (read-only streaming).
//   Grants are registered and round-robin on contention, with a per-grant cycle quantum.
//   Read-valid is returned only to the master that issued the read, even across grant handovers.
// PARAMETERS
//   ADDR_W        13   memory word address width
//   DATA_W        256  memory data width; BE_W = DATA_W/8
//   READ_LATENCY  2    cycles from accepted read to onchip_mem_read_data valid (>=1)
//   MAX_GRANT     64   max consecutive owned cycles while the other master waits (>=2)
// PORTS  (mX_* exists for X=0 and X=1; m1 has no write ports)
//   mem_clk               in   1       clock
//   mem_rst_n             in   1       synchronous reset, active low
//   mX_req                in   1       master wants ownership; hold high for the whole burst
//   mX_gnt                out  1       registered grant; an access is accepted only when high
//   mX_read               in   1       read strobe
//   mX_addr               in   ADDR_W  word address
//   m0_write              in   1       write strobe (M0 only)
//   m0_byte_enable        in   BE_W    write byte enables
//   m0_write_data         in   DATA_W  write data
//   mX_read_valid         out  1       read data valid for this master
//   mX_read_data          out  DATA_W  = onchip_mem_read_data (broadcast; qualify with mX_read_valid)
//   onchip_mem_chip_select out 1       high in any cycle with an accepted access
//   onchip_mem_clk_ena    out  1       constant 1 after reset
//   onchip_mem_addr       out  ADDR_W  address of the accepted access, else 0
//   onchip_mem_write      out  1       accepted M0 write
//   onchip_mem_byte_enable out BE_W    M0 byte enables when writing, else 0
//   onchip_mem_write_data out  DATA_W  M0 write data when writing, else 0
//   onchip_mem_read_data  in   DATA_W  memory read data
//   protocol_err          out  1       sticky: access without grant, or read+write same cycle
// BEHAVIOUR
//   Reset: state=IDLE, mX_gnt=0, mX_read_valid=0, valid pipeline cleared, rr pointer -> M0 favoured,
//     quantum counter=0, protocol_err=0, onchip_mem_clk_ena=0. In-flight reads at reset are dropped.
//   FSM states IDLE, OWN0, OWN1; mX_gnt = (state==OWNX), registered.
//   IDLE: only one req -> that OWN next cycle; both -> master indicated by rr pointer.
//   OWNX: owner drops req -> OWN(other) if other req, else IDLE (no idle gap on handover).
//     Owner holds req, other req, counter==MAX_GRANT-1 -> OWN(other) next cycle.
//     Owner holds req, other idle -> stay; counter saturates at MAX_GRANT-1.
//   Counter clears on every state change; increments each owned cycle.
//   rr pointer flips to the non-owner on every entry to OWN0/OWN1.
//   Accept rule: access accepted in cycle t iff mX_gnt && (mX_read || m0_write), combinational mux
//     from the granted master to onchip_mem_* in the same cycle (zero added latency).
//   m0_read && m0_write together: write accepted, read dropped, protocol_err set.
//   Strobe while mX_gnt=0: ignored (no memory access), protocol_err set.
//   Read return: accepted read at t -> mX_read_valid=1 at t+READ_LATENCY for the issuing master only,
//     via a READ_LATENCY-deep {valid, owner} shift register; unaffected by grant changes after t.
//   Back-to-back reads: one per cycle, full throughput; valids are contiguous.
//   protocol_err clears only on reset.
// TESTING
//   M1 req alone, reads addr 0..7 each cycle -> m1_gnt at +1 cycle, m1_read_valid 8 contiguous cycles
//     starting 2 cycles after first read, m0_read_valid stays 0.
//   Both req same cycle after reset -> M0 granted first; M0 drops req after 3 cycles -> m1_gnt next cycle, no gap.
//   MAX_GRANT=4, both hold req continuously -> grant alternates M0 4 cycles, M1 4 cycles, repeating.
//   M1 reads addr 5 on its last owned cycle, M0 granted next cycle -> valid for addr 5 goes to m1_read_valid only.
//   M0 writes 0xA5.. with byte_enable=32'h0000_000F to addr 0x10, then reads it -> write strobe 1 cycle,
//     read data low 4 bytes updated; m0_read+m0_write same cycle -> protocol_err=1 and stays 1.
//   Assert mem_rst_n=0 with 2 reads in flight -> no read_valid after reset, all grants 0, state IDLE.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for the single-port on-chip frame memory: M0 read/write, M1 read-only.
// Registered round-robin grants with a per-grant quantum; read-valid follows the issuing master.
module onchip_mem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 256,
    parameter int READ_LATENCY = 2,
    parameter int MAX_GRANT    = 64,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              m0_req,
    output logic              m0_gnt,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byte_enable,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic              m0_read_valid,
    output logic [DATA_W-1:0] m0_read_data,
    input  logic              m1_req,
    output logic              m1_gnt,
    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_read_valid,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              onchip_mem_chip_select,
    output logic              onchip_mem_clk_ena,
    output logic [ADDR_W-1:0] onchip_mem_addr,
    output logic              onchip_mem_write,
    output logic [BE_W-1:0]   onchip_mem_byte_enable,
    output logic [DATA_W-1:0] onchip_mem_write_data,
    input  logic [DATA_W-1:0] onchip_mem_read_data,
    output logic              protocol_err
);
    localparam int CNT_W = (MAX_GRANT > 2) ? $clog2(MAX_GRANT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_GRANT - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                  state;
    logic                    rr;          // 0: M0 wins the next tie
    logic [CNT_W-1:0]        cnt;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] own_pipe;    // 1: read belongs to M1
    logic                    wr0, rd0, rd1, viol;

    assign m0_gnt = (state == OWN0);
    assign m1_gnt = (state == OWN1);

    // A simultaneous read+write from M0 keeps the write and drops the read.
    assign wr0  = m0_gnt & m0_write;
    assign rd0  = m0_gnt & m0_read & ~m0_write;
    assign rd1  = m1_gnt & m1_read;
    assign viol = (m0_read & m0_write) | (~m0_gnt & (m0_read | m0_write)) | (~m1_gnt & m1_read);

    assign onchip_mem_chip_select = wr0 | rd0 | rd1;
    assign onchip_mem_write       = wr0;
    assign onchip_mem_addr        = (wr0 | rd0) ? m0_addr : (rd1 ? m1_addr : '0);
    assign onchip_mem_byte_enable = wr0 ? m0_byte_enable : '0;
    assign onchip_mem_write_data  = wr0 ? m0_write_data : '0;

    assign m0_read_data  = onchip_mem_read_data;
    assign m1_read_data  = onchip_mem_read_data;
    assign m0_read_valid = vld_pipe[READ_LATENCY-1] & ~own_pipe[READ_LATENCY-1];
    assign m1_read_valid = vld_pipe[READ_LATENCY-1] &  own_pipe[READ_LATENCY-1];

    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            state              <= IDLE;
            rr                 <= 1'b0;
            cnt                <= '0;
            vld_pipe           <= '0;
            own_pipe           <= '0;
            protocol_err       <= 1'b0;
            onchip_mem_clk_ena <= 1'b0;
        end else begin
            onchip_mem_clk_ena <= 1'b1;
            if (viol)
                protocol_err <= 1'b1;

            vld_pipe[0] <= rd0 | rd1;
            own_pipe[0] <= rd1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (m0_req && (!m1_req || !rr)) begin
                        state <= OWN0;
                        rr    <= 1'b1;
                    end else if (m1_req) begin
                        state <= OWN1;
                        rr    <= 1'b0;
                    end
                end
                OWN0: begin
                    if (!m0_req || (m1_req && cnt == LAST)) begin
                        cnt   <= '0;
                        state <= m1_req ? OWN1 : IDLE;
                        if (m1_req)
                            rr <= 1'b0;
                    end else if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OWN1: begin
                    if (!m1_req || (m0_req && cnt == LAST)) begin
                        cnt   <= '0;
                        state <= m0_req ? OWN0 : IDLE;
                        if (m0_req)
                            rr <= 1'b1;
                    end else if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a 2-cycle-latency memory model behind it.
module tb_onchip_mem_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 256;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_req = 0, m0_read = 0, m0_write = 0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [BE_W-1:0]   m0_be = '0;
    logic [DATA_W-1:0] m0_wd = '0;
    logic              m1_req = 0, m1_read = 0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic              m0_gnt, m1_gnt, m0_rv, m1_rv;
    logic [DATA_W-1:0] m0_rd, m1_rd;
    logic              cs, clk_ena, mwrite, perr;
    logic [ADDR_W-1:0] maddr;
    logic [BE_W-1:0]   mbe;
    logic [DATA_W-1:0] mwd, mrd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(2), .MAX_GRANT(4)) dut (
        .mem_clk(clk), .mem_rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_read(m0_read), .m0_addr(m0_addr),
        .m0_write(m0_write), .m0_byte_enable(m0_be), .m0_write_data(m0_wd),
        .m0_read_valid(m0_rv), .m0_read_data(m0_rd),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_read(m1_read), .m1_addr(m1_addr),
        .m1_read_valid(m1_rv), .m1_read_data(m1_rd),
        .onchip_mem_chip_select(cs), .onchip_mem_clk_ena(clk_ena), .onchip_mem_addr(maddr),
        .onchip_mem_write(mwrite), .onchip_mem_byte_enable(mbe), .onchip_mem_write_data(mwd),
        .onchip_mem_read_data(mrd), .protocol_err(perr)
    );

    function automatic logic [DATA_W-1:0] pat(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    // Memory model: byte-enabled writes, reads return two cycles after acceptance
    logic [DATA_W-1:0] mem [0:63];
    logic [DATA_W-1:0] d1, d2;
    bit init_done = 0;
    assign mrd = d2;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
            init_done <= 1;
        end else if (cs && mwrite) begin
            for (int b = 0; b < BE_W; b++)
                if (mbe[b]) mem[maddr[5:0]][b*8 +: 8] <= mwd[b*8 +: 8];
        end
        d1 <= (cs && !mwrite) ? mem[maddr[5:0]] : '0;
        d2 <= d1;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m0_req = 0; m0_read = 0; m0_write = 0; m0_addr = '0; m0_be = '0; m0_wd = '0;
        m1_req = 0; m1_read = 0; m1_addr = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    logic [DATA_W-1:0] exp_w;

    initial begin
        // reset state
        clear_in();
        tick();
        tick();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_rv", {m0_rv, m1_rv}, 0);
        chk("rst_perr", perr, 0);
        chk("rst_clk_ena", clk_ena, 0);
        rst_n = 1;
        tick();
        chk("clk_ena_on", clk_ena, 1);

        // M1 alone streams addr 0..7
        m1_req = 1;
        tick();
        chk("m1_gnt_solo", m1_gnt, 1);
        chk("m0_gnt_solo", m0_gnt, 0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            m1_read = (k < 8);
            m1_addr = ADDR_W'(k);
            #1;
            if (k < 8) begin
                chk("stream_cs", cs, 1);
                chk("stream_addr", maddr, k);
            end
            chk("stream_m1_rv", m1_rv, k >= 2);
            chk("stream_m0_rv", m0_rv, 0);
            if (k >= 2) chk("stream_data", m1_rd, pat(k - 2));
        end
        tick();
        m1_req = 0; m1_read = 0;
        #1;
        chk("stream_tail_rv", m1_rv, 0);
        tick();
        chk("stream_release", m1_gnt, 0);

        // simultaneous requests after reset: M0 first, handover with no gap
        do_reset();
        tick();
        m0_req = 1; m1_req = 1;
        tick();
        chk("tie_m0_first", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        chk("tie_m0_hold", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 0;
        #1;
        chk("tie_m0_last", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        chk("tie_handover", {m0_gnt, m1_gnt}, 2'b01);
        clear_in();
        tick();
        tick();
        chk("tie_idle", {m0_gnt, m1_gnt}, 2'b00);

        // saturated quantum: a late M1 request takes over after one cycle
        do_reset();
        tick();
        m0_req = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) m1_req = 1;
            chk("sat_m0_own", {m0_gnt, m1_gnt}, 2'b10);
        end
        tick();
        chk("sat_switch", {m0_gnt, m1_gnt}, 2'b01);

        // quantum alternation; read on M1's last owned cycle returns to M1 only
        do_reset();
        tick();
        m0_req = 1; m1_req = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            m1_read = (k == 8); m1_addr = 5;
            m0_read = (k == 9); m0_addr = 6;
            #1;
            chk("alt_m0_gnt", m0_gnt, ((k - 1) / 4) % 2 == 0);
            chk("alt_m1_gnt", m1_gnt, ((k - 1) / 4) % 2 == 1);
            chk("alt_m1_rv", m1_rv, k == 10);
            chk("alt_m0_rv", m0_rv, k == 11);
            if (k == 8) chk("alt_m1_addr", maddr, 5);
            if (k == 10) chk("alt_m1_data", m1_rd, pat(5));
            if (k == 11) chk("alt_m0_data", m0_rd, pat(6));
        end
        chk("alt_perr", perr, 0);

        // M0 byte-enabled write then read back; then read+write collision
        do_reset();
        tick();
        m0_req = 1;
        tick();
        m0_write = 1; m0_addr = 13'h10; m0_be = 32'h0000_000F; m0_wd = {32{8'hA5}};
        #1;
        chk("wr_strobe", mwrite, 1);
        chk("wr_cs", cs, 1);
        chk("wr_addr", maddr, 13'h10);
        chk("wr_be", mbe, 32'h0000_000F);
        chk("wr_data", mwd, {32{8'hA5}});
        tick();
        m0_write = 0; m0_read = 1;
        #1;
        chk("rd_no_wr", mwrite, 0);
        chk("rd_be_zero", mbe, 0);
        chk("rd_wd_zero", mwd, 0);
        tick();
        m0_read = 0;
        tick();
        exp_w = pat(16);
        exp_w[31:0] = 32'hA5A5_A5A5;
        chk("rb_valid", m0_rv, 1);
        chk("rb_m1_rv", m1_rv, 0);
        chk("rb_data", m0_rd, exp_w);
        chk("rb_perr", perr, 0);
        tick();
        m0_read = 1; m0_write = 1; m0_addr = 13'h11; m0_be = '0;
        #1;
        chk("rw_write_wins", mwrite, 1);
        tick();
        m0_read = 0; m0_write = 0;
        #1;
        chk("rw_perr", perr, 1);
        tick();
        chk("rw_read_dropped", m0_rv, 0);
        repeat (3) tick();
        chk("rw_perr_sticky", perr, 1);

        // reset with two reads in flight
        do_reset();
        tick();
        m1_req = 1;
        tick();
        m1_read = 1; m1_addr = 0;
        tick();
        m1_addr = 1;
        tick();
        clear_in();
        rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 1) rst_n = 1;
            chk("flight_rv", {m0_rv, m1_rv}, 0);
            chk("flight_gnt", {m0_gnt, m1_gnt}, 0);
        end
        chk("flight_perr", perr, 0);

        // strobe without grant is ignored and flagged
        m1_read = 1; m1_addr = 3;
        #1;
        chk("nogrant_cs", cs, 0);
        tick();
        m1_read = 0;
        #1;
        chk("nogrant_perr", perr, 1);
        chk("nogrant_gnt", m1_gnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
